// File: rtl/inst_fetch.sv
// Fetches a 1-byte opcode then a 0/4/8-byte operand and holds it for execute; zero-wait memory gives one access per cycle.
// Execute backpressure (inst_ready=0) freezes HOLD; redirects mid-access drain the outstanding read before refetching.
module inst_fetch #(
    parameter int              AW       = 16,
    parameter int              DW       = 64,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          halt,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_size,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [7:0]    inst_opc,
    output logic [DW-1:0] inst_opl,
    output logic [AW-1:0] inst_pc,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, OPCFT, OPLFT, HOLD, DRAIN} state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] tgt_q;
    logic [AW-1:0] ipc_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          req_q;
    logic          valid_q;
    logic [7:0]    opc_q;
    logic [DW-1:0] opl_q;

    logic [AW-1:0] pc_inc_d;
    logic [DW-1:0] opl_d;
    logic [1:0]    oplsz_d;
    logic          restart_d;
    logic [AW-1:0] restart_pc_d;

    always_comb begin
        pc_inc_d = pc_q + ((size_q == 2'd2) ? AW'(8) : (size_q == 2'd1) ? AW'(4) : AW'(1));
        opl_d    = mem_rdata & ((size_q == 2'd2) ? DW'(64'hFFFF_FFFF_FFFF_FFFF)
                                                 : DW'(64'h0000_0000_FFFF_FFFF));
        oplsz_d  = mem_rdata[0] ? 2'd2 : (mem_rdata[1] ? 2'd1 : 2'd0);
    end

    // Every path that begins a fresh opcode fetch, with the PC it starts from.
    always_comb begin
        restart_d    = 1'b0;
        restart_pc_d = redirect_pc;
        case (state_q)
            IDLE: begin
                restart_d    = run;
                restart_pc_d = RESET_PC;
            end
            OPCFT, OPLFT: restart_d = redirect & mem_ack;
            HOLD: begin
                restart_d    = redirect | (inst_ready & ~halt);
                restart_pc_d = redirect ? redirect_pc : pc_q;
            end
            DRAIN: begin
                restart_d    = mem_ack;
                restart_pc_d = redirect ? redirect_pc : tgt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            ipc_q   <= '0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            opc_q   <= 8'd0;
            opl_q   <= '0;
        end else if (restart_d) begin
            state_q <= OPCFT;
            pc_q    <= restart_pc_d;
            addr_q  <= restart_pc_d;
            size_q  <= 2'd0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                OPCFT, OPLFT: begin
                    if (redirect) begin
                        tgt_q   <= redirect_pc;
                        state_q <= DRAIN;
                    end else if (mem_ack) begin
                        pc_q <= pc_inc_d;
                        if (state_q == OPCFT) begin
                            opc_q <= mem_rdata[7:0];
                            ipc_q <= pc_q;
                            opl_q <= '0;
                        end else begin
                            opl_q <= opl_d;
                        end
                        if (state_q == OPCFT && oplsz_d != 2'd0) begin
                            state_q <= OPLFT;
                            addr_q  <= pc_inc_d;
                            size_q  <= oplsz_d;
                        end else begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                            addr_q  <= '0;
                            size_q  <= 2'd0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready && halt) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        pc_q    <= RESET_PC;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        tgt_q <= redirect_pc;
                    end
                end
                IDLE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign mem_size   = size_q;
    assign inst_valid = valid_q;
    assign inst_opc   = valid_q ? opc_q : 8'd0;
    assign inst_opl   = valid_q ? opl_q : '0;
    assign inst_pc    = valid_q ? ipc_q : '0;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter AW, default 16: byte-address width of PC and memory address.
REQ-002 Parameter DW, default 64: data width, a multiple of 8 and at least 64.
REQ-003 Parameter RESET_PC, default 0: PC value after reset and on leaving IDLE.
REQ-004 Ports, in order:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  start fetching from IDLE.
- halt  in  1  qualifies an accepted instruction as the last one.
- redirect  in  1  branch taken.
- redirect_pc  in  AW  branch target.
- mem_req  out  1  memory read request.
- mem_addr  out  AW  request byte address.
- mem_size  out  2  request size: 0 = 1 B, 1 = 4 B, 2 = 8 B.
- mem_ack  in  1  read complete, rdata valid.
- mem_rdata  in  DW  read data, little-endian, low bytes valid per size.
- inst_valid  out  1  instruction available.
- inst_ready  in  1  execute stage accepts.
- inst_opc  out  8  opcode.
- inst_opl  out  DW  operand, zero-extended.
- inst_pc  out  AW  opcode address.
- busy  out  1  state is not IDLE.

Function
REQ-005 States: IDLE, OPCFT, OPLFT, HOLD, DRAIN.
REQ-006 IDLE: all outputs are 0. When run=1: PC=RESET_PC, go to OPCFT.
REQ-007 OPCFT drives mem_req=1, mem_addr=PC, mem_size=0.
REQ-008 In OPCFT, on mem_ack: opc=rdata[7:0], PC+=1.
REQ-009 Operand length after an opcode:
- opc[0]=1: 8 B.
- else opc[1]=1: 4 B.
- else 0 B, go directly to HOLD.
REQ-010 OPLFT drives mem_req=1, mem_addr=PC, mem_size=2 or 1.
REQ-011 In OPLFT, on mem_ack: opl = rdata zero-extended to the requested size, PC += length, go to HOLD.
REQ-012 For a 0-byte operand, inst_opl=0.
REQ-013 mem_addr and mem_size stay stable while mem_req=1 and mem_ack=0.
REQ-014 mem_req deasserts in the cycle after ack, except when the next request is issued back-to-back.
REQ-015 Back-to-back issue is allowed: a zero-wait ack gives 1 cycle per access.
REQ-016 HOLD: inst_valid=1; inst_opc, inst_opl and inst_pc stay stable until inst_ready=1.
REQ-017 HOLD acceptance (inst_valid & inst_ready) with halt=0: go to OPCFT at the current PC.
REQ-018 HOLD acceptance with halt=1: go to IDLE.
REQ-019 Best-case latency from run to inst_valid with zero-wait memory:
- 2 cycles, 0-byte operand.
- 3 cycles, 4/8-byte operand.
REQ-020 redirect in IDLE is ignored.
REQ-021 redirect in HOLD: drop inst_valid next cycle, PC=redirect_pc, go to OPCFT. Redirect takes priority over acceptance; halt is ignored.
REQ-022 redirect in OPCFT/OPLFT with mem_ack=0 in the same cycle: latch redirect_pc, go to DRAIN.
REQ-023 redirect coinciding with mem_ack: discard the data, PC=redirect_pc, go to OPCFT.
REQ-024 DRAIN holds mem_req, addr and size until mem_ack, discards the data, then fetches from the latched target in OPCFT. A later redirect in DRAIN overwrites the latched target.
REQ-025 PC arithmetic is modulo 2^AW; wrap to 0 is legal, including mid-instruction (opcode at 2^AW-1, operand at 0).
REQ-026 inst_valid is never 1 outside HOLD; discarded data never reaches inst_*.
REQ-027 run while busy=1 is ignored.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, PC=RESET_PC and all outputs to 0, including mid-transaction.
REQ-029 A mem_ack arriving after reset release with no outstanding request is ignored.

Verification
REQ-030 Zero-wait memory, RESET_PC=0, mem[0]=0x81, mem[1..8]=0x1122334455667788, run pulse:
- inst_valid 3 cycles later with opc=0x81, opl=0x1122334455667788, pc=0.
- Next fetch at 9.
REQ-031 opc=0x02 at 0x10 with 4-byte operand 0xDEADBEEF, inst_ready held 0 for 5 cycles:
- outputs are stable throughout.
- After acceptance, next mem_addr=0x15.
REQ-032 redirect to 0x40 during an OPLFT with 3 wait cycles:
- request held until ack, data discarded.
- Next mem_addr=0x40; no inst_valid for the dropped instruction.
REQ-033 redirect coincident with an acceptance in HOLD: next fetch at redirect_pc, not at sequential PC.
REQ-034 Opcode 0x01 at 0xFFFF (AW=16): operand fetched from 0x0000; inst_pc=0xFFFF; next PC=0x0008.
REQ-035 rst_n asserted while mem_req=1: outputs 0 immediately; after release, busy=0 until run.
